fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 12'h000, is the PC value loaded on reset.
REQ-002 Parameter NOP_INSTR, default 32'h00000013, is the bubble word written into IF/ID on flush or halt.
REQ-003 Parameter HALT_INSTR, default 32'h00100073, is the EBREAK encoding that halts fetch.
REQ-004 clk  input  1  is the single clock; all state changes SHALL occur on its rising edge.
REQ-005 rst  input  1  is the asynchronous, active-high reset.
REQ-006 stall  input  1  requests a hold of PC and the IF/ID register.
REQ-007 redirect  input  1  is a branch/jump taken request.
REQ-008 redirect_target  input  12  is the byte address of the branch/jump target.
REQ-009 instr_in  input  32  is the instruction word from the instruction memory; the memory read is combinational on address, so it is valid in the same cycle.
REQ-010 address  output  12  is the PC driven to the instruction memory.
REQ-011 if_id_instr  output  32  is the registered fetched instruction.
REQ-012 if_id_pc  output  12  is the registered PC of if_id_instr.
REQ-013 if_id_valid  output  1  is high when if_id_instr is a real fetched instruction.
REQ-014 misalign_err  output  1  is a one-cycle pulse flagging a redirect target with nonzero bits [1:0].
REQ-015 halted  output  1  is high while the FSM is in HALT.
REQ-016 fetch_count  output  16  is the count of instructions captured into IF/ID, saturating at 16'hFFFF.

Function
REQ-017 The FSM SHALL have three states: BOOT, RUN and HALT.
REQ-018 BOOT SHALL last exactly one cycle after reset release, with PC held and IF/ID unchanged, then move to RUN.
REQ-019 address SHALL equal the PC register at all times.
REQ-020 In RUN, redirect SHALL have top priority: PC <= {redirect_target[11:2],2'b00}, if_id_instr <= NOP_INSTR, if_id_valid <= 0, and fetch_count is held.
REQ-021 In RUN, a redirect with redirect_target[1:0] != 0 SHALL assert misalign_err on the following cycle only; the redirect is still taken.
REQ-022 In RUN with stall=1 and redirect=0, PC, IF/ID and fetch_count SHALL hold.
REQ-023 In RUN with stall=0 and redirect=0, the unit SHALL set if_id_instr <= instr_in, if_id_pc <= PC and if_id_valid <= 1, increment fetch_count, and advance PC by 4.
REQ-024 PC arithmetic SHALL be 12-bit modulo: 12'hFFC + 4 = 12'h000.
REQ-025 On a non-stalled capture in RUN with instr_in == HALT_INSTR, the word SHALL be captured normally, PC SHALL hold, and the FSM SHALL enter HALT.
REQ-026 In HALT with stall=0, if_id_instr <= NOP_INSTR and if_id_valid <= 0; with stall=1, IF/ID SHALL hold.
REQ-027 In HALT, redirect SHALL be ignored, PC SHALL stay frozen, and misalign_err SHALL stay 0.
REQ-028 HALT SHALL be left only by reset.
REQ-029 misalign_err SHALL be 0 in every cycle not covered by REQ-021.

Reset
REQ-030 While rst=1, regardless of clk, the unit SHALL force: state=BOOT, PC=RESET_PC, if_id_instr=NOP_INSTR, if_id_pc=0, if_id_valid=0, misalign_err=0, fetch_count=0 and halted=0.
REQ-031 Reset asserted mid-operation, including during stall, redirect or HALT, SHALL take effect immediately and discard all pending state.

Verification
REQ-032 Sequential fetch: release reset with memory holding words W0..W3 at 0,4,8,12 and stall=redirect=0 -> edge 1 leaves address=0 and valid=0; edges 2..5 give if_id_pc 0,4,8,12 with W0..W3, valid=1 and fetch_count 1..4.
REQ-033 Stall: assert stall for 3 cycles after the capture at PC=4 -> address=8 and IF/ID=(4,W1) hold for all 3 cycles, fetch_count does not change, and PC=8 is fetched after release.
REQ-034 Redirect plus misalign: redirect=1 with target=12'h0A6 while stall=1 -> next cycle PC=0x0A4, IF/ID=NOP, valid=0, misalign_err=1 for one cycle; the following capture has if_id_pc=0x0A4.
REQ-035 Wrap-around: redirect to 12'hFFC -> the capture has if_id_pc=0xFFC and address becomes 0x000.
REQ-036 Halt: memory word at 0x010 is 32'h00100073 -> it is captured with valid=1; halted=1 from the next cycle; then valid=0 with IF/ID=NOP; a later redirect leaves address=0x010; asserting rst mid-cycle returns address to 0x000 immediately.

Source files
------------

// File: rtl/fetch_if.sv
// Fetch unit port bundle: pipeline control in, instruction memory, IF/ID stage and status out.
interface fetch_if;
    logic        stall;
    logic        redirect;
    logic [11:0] redirect_target;
    logic [31:0] instr_in;
    logic [11:0] address;
    logic [31:0] if_id_instr;
    logic [11:0] if_id_pc;
    logic        if_id_valid;
    logic        misalign_err;
    logic        halted;
    logic [15:0] fetch_count;

    // Fetch unit side.
    modport master (
        input  stall, redirect, redirect_target, instr_in,
        output address, if_id_instr, if_id_pc, if_id_valid, misalign_err, halted, fetch_count
    );

    // Pipeline / memory side.
    modport slave (
        output stall, redirect, redirect_target, instr_in,
        input  address, if_id_instr, if_id_pc, if_id_valid, misalign_err, halted, fetch_count
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and a BOOT/RUN/HALT FSM.
// Redirects beat stalls; an EBREAK capture freezes fetch until reset.
module fetch_unit #(
    parameter logic [11:0] RESET_PC   = 12'h000,
    parameter logic [31:0] NOP_INSTR  = 32'h00000013,
    parameter logic [31:0] HALT_INSTR = 32'h00100073
) (
    input logic     clk,
    input logic     rst,
    fetch_if.master bus
);

    typedef enum logic [1:0] {StBoot, StRun, StHalt} state_e;

    state_e      state_q, state_d;
    logic [11:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [11:0] ifpc_q, ifpc_d;
    logic        valid_q, valid_d;
    logic        mis_q, mis_d;
    logic [15:0] count_q, count_d;

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StBoot;
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            ifpc_q  <= 12'h000;
            valid_q <= 1'b0;
            mis_q   <= 1'b0;
            count_q <= 16'h0000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            ifpc_q  <= ifpc_d;
            valid_q <= valid_d;
            mis_q   <= mis_d;
            count_q <= count_d;
        end
    end

    // Next-state logic: hold by default, misalign flag is a single-cycle pulse.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        ifpc_d  = ifpc_q;
        valid_d = valid_q;
        mis_d   = 1'b0;
        count_d = count_q;
        unique case (state_q)
            StBoot: begin
                state_d = StRun;
            end
            StRun: begin
                if (bus.redirect) begin
                    pc_d    = {bus.redirect_target[11:2], 2'b00};
                    instr_d = NOP_INSTR;
                    valid_d = 1'b0;
                    mis_d   = |bus.redirect_target[1:0];
                end else if (!bus.stall) begin
                    instr_d = bus.instr_in;
                    ifpc_d  = pc_q;
                    valid_d = 1'b1;
                    if (count_q != 16'hFFFF) begin
                        count_d = count_q + 16'd1;
                    end
                    // EBREAK is captured but the PC stays parked on it.
                    if (bus.instr_in == HALT_INSTR) begin
                        state_d = StHalt;
                    end else begin
                        pc_d = pc_q + 12'd4;
                    end
                end
            end
            StHalt: begin
                if (!bus.stall) begin
                    instr_d = NOP_INSTR;
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = StBoot;
            end
        endcase
    end

    // Output mapping.
    always_comb begin
        bus.address      = pc_q;
        bus.if_id_instr  = instr_q;
        bus.if_id_pc     = ifpc_q;
        bus.if_id_valid  = valid_q;
        bus.misalign_err = mis_q;
        bus.halted       = (state_q == StHalt);
        bus.fetch_count  = count_q;
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: vector table for fetch/stall/redirect/wrap, hand-written
// sequences for halt and mid-cycle reset. Memory word at byte address A is 32'h1000_0000 + A,
// except 0x010 which holds EBREAK.
module tb_fetch_unit;

    localparam logic [31:0] NOP  = 32'h00000013;
    localparam logic [31:0] HALT = 32'h00100073;

    logic clk;
    logic rst;
    fetch_if ifc ();

    logic [31:0] mem [0:1023];

    int tests_run;
    int tests_failed;

    fetch_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.master)
    );

    assign ifc.instr_in = mem[ifc.address[11:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        redirect;
        logic [11:0] target;
        logic [11:0] address;
        logic [11:0] pc;
        logic [31:0] instr;
        logic        valid;
        logic        mis;
        logic        halted;
        logic [15:0] count;
    } vec_t;

    localparam int NumVecs = 19;
    vec_t vecs [0:NumVecs-1];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input vec_t v);
        check({tag, " address"}, 32'(ifc.address), 32'(v.address));
        check({tag, " if_id_pc"}, 32'(ifc.if_id_pc), 32'(v.pc));
        check({tag, " if_id_instr"}, ifc.if_id_instr, v.instr);
        check({tag, " if_id_valid"}, 32'(ifc.if_id_valid), 32'(v.valid));
        check({tag, " misalign_err"}, 32'(ifc.misalign_err), 32'(v.mis));
        check({tag, " halted"}, 32'(ifc.halted), 32'(v.halted));
        check({tag, " fetch_count"}, 32'(ifc.fetch_count), 32'(v.count));
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        for (int i = 0; i < 1024; i++) begin
            mem[i] = 32'h1000_0000 + 32'(i * 4);
        end
        mem[4] = HALT;

        rst                 = 1'b1;
        ifc.stall           = 1'b0;
        ifc.redirect        = 1'b0;
        ifc.redirect_target = 12'h000;

        //          rst  stl  red  target   addr     pc       instr          v    m    h    count
        // Sequential fetch from reset.
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 12'h000, 12'h000, 12'h000, NOP,          1'b0, 1'b0, 1'b0, 16'd0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 12'h000, 12'h000, 12'h000, NOP,          1'b0, 1'b0, 1'b0, 16'd0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 12'h000, 12'h004, 12'h000, 32'h10000000, 1'b1, 1'b0, 1'b0, 16'd1};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 12'h000, 12'h008, 12'h004, 32'h10000004, 1'b1, 1'b0, 1'b0, 16'd2};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 12'h000, 12'h00C, 12'h008, 32'h10000008, 1'b1, 1'b0, 1'b0, 16'd3};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 12'h000, 12'h010, 12'h00C, 32'h1000000C, 1'b1, 1'b0, 1'b0, 16'd4};
        // Reset again, then stall for 3 cycles after the capture at PC=4.
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 12'h000, 12'h000, 12'h000, NOP,          1'b0, 1'b0, 1'b0, 16'd0};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 12'h000, 12'h000, 12'h000, NOP,          1'b0, 1'b0, 1'b0, 16'd0};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 12'h000, 12'h004, 12'h000, 32'h10000000, 1'b1, 1'b0, 1'b0, 16'd1};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 12'h000, 12'h008, 12'h004, 32'h10000004, 1'b1, 1'b0, 1'b0, 16'd2};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 12'h000, 12'h008, 12'h004, 32'h10000004, 1'b1, 1'b0, 1'b0, 16'd2};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 12'h000, 12'h008, 12'h004, 32'h10000004, 1'b1, 1'b0, 1'b0, 16'd2};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 12'h000, 12'h008, 12'h004, 32'h10000004, 1'b1, 1'b0, 1'b0, 16'd2};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 12'h000, 12'h00C, 12'h008, 32'h10000008, 1'b1, 1'b0, 1'b0, 16'd3};
        // Misaligned redirect under stall, then the capture at the aligned target.
        vecs[14] = '{1'b0, 1'b1, 1'b1, 12'h0A6, 12'h0A4, 12'h008, NOP,          1'b0, 1'b1, 1'b0, 16'd3};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 12'h000, 12'h0A8, 12'h0A4, 32'h100000A4, 1'b1, 1'b0, 1'b0, 16'd4};
        // Redirect to the top of the address space and wrap.
        vecs[16] = '{1'b0, 1'b0, 1'b1, 12'hFFC, 12'hFFC, 12'h0A4, NOP,          1'b0, 1'b0, 1'b0, 16'd4};
        vecs[17] = '{1'b0, 1'b0, 1'b0, 12'h000, 12'h000, 12'hFFC, 32'h10000FFC, 1'b1, 1'b0, 1'b0, 16'd5};
        vecs[18] = '{1'b0, 1'b0, 1'b0, 12'h000, 12'h004, 12'h000, 32'h10000000, 1'b1, 1'b0, 1'b0, 16'd6};

        #2;
        check("reset address", 32'(ifc.address), 32'h000);
        check("reset instr", ifc.if_id_instr, NOP);

        for (int i = 0; i < NumVecs; i++) begin
            @(negedge clk);
            rst                 = vecs[i].rst;
            ifc.stall           = vecs[i].stall;
            ifc.redirect        = vecs[i].redirect;
            ifc.redirect_target = vecs[i].target;
            edge_step();
            check_all($sformatf("vec%0d", i), vecs[i]);
        end

        // Halt sequence: run from reset up to the EBREAK at 0x010.
        @(negedge clk);
        rst          = 1'b1;
        ifc.stall    = 1'b0;
        ifc.redirect = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) edge_step();  // boot + captures at 0,4,8,C
        check("pre-halt address", 32'(ifc.address), 32'h010);
        check("pre-halt count", 32'(ifc.fetch_count), 32'd4);
        edge_step();
        check("halt capture instr", ifc.if_id_instr, HALT);
        check("halt capture pc", 32'(ifc.if_id_pc), 32'h010);
        check("halt capture valid", 32'(ifc.if_id_valid), 32'd1);
        check("halt capture count", 32'(ifc.fetch_count), 32'd5);
        check("halt pc frozen", 32'(ifc.address), 32'h010);
        check("halted set", 32'(ifc.halted), 32'd1);
        edge_step();
        check("halt bubble instr", ifc.if_id_instr, NOP);
        check("halt bubble valid", 32'(ifc.if_id_valid), 32'd0);
        check("halt count held", 32'(ifc.fetch_count), 32'd5);
        @(negedge clk);
        ifc.redirect        = 1'b1;
        ifc.redirect_target = 12'h0A6;
        edge_step();
        check("halt redirect ignored", 32'(ifc.address), 32'h010);
        check("halt no misalign", 32'(ifc.misalign_err), 32'd0);
        check("halt still halted", 32'(ifc.halted), 32'd1);
        @(negedge clk);
        ifc.redirect = 1'b0;

        // Reset asserted mid-cycle must act without a clock edge.
        #2;
        rst = 1'b1;
        #1;
        check("async rst address", 32'(ifc.address), 32'h000);
        check("async rst halted", 32'(ifc.halted), 32'd0);
        check("async rst count", 32'(ifc.fetch_count), 32'd0);
        check("async rst instr", ifc.if_id_instr, NOP);
        @(negedge clk);
        rst = 1'b0;
        edge_step();
        edge_step();
        check("post-reset fetch pc", 32'(ifc.if_id_pc), 32'h000);
        check("post-reset fetch valid", 32'(ifc.if_id_valid), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
